snoop_responder: RTL and testbench
==================================

SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 2, 32-bit words per cache block; DW = 32*BLOCK_SIZE.
REQ-002 SHALL have CLK  input  1  clock; all flops on rising edge.
REQ-003 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ccwait  input  1  bus snoop request to this cache.
REQ-005 SHALL have ccinv  input  1  bus invalidate qualifier for the current snoop.
REQ-006 SHALL have ccsnoopaddr  input  32  snooped block address.
REQ-007 SHALL have ccsnoophit  output  1  local copy is in M or E; this cache supplies.
REQ-008 SHALL have ccexclusivehit  output  1  local copy is valid (M, E or S).
REQ-009 SHALL have ccsnoopdone  output  1  ccsnoophit, ccexclusivehit and dstore are valid.
REQ-010 SHALL have dstore  output  DW  supplied block data.
REQ-011 SHALL have dwait  input  1  bus writeback of supplied data still pending.
REQ-012 SHALL have tag_req / tag_addr  output  1 / 32  tag-array lookup request and address.
REQ-013 SHALL have tag_ack / tag_hit / tag_state / tag_data  input  1 / 1 / 2 / DW  lookup result.
REQ-014 SHALL have state_wen / state_new  output  1 / 2  one-cycle MESI state write to the snooped line.
REQ-015 SHALL have cpu_stall  output  1  freezes the local cache pipeline during a snoop.

Function
REQ-016 SHALL implement FSM states IDLE, LOOKUP, RESPOND, UPDATE.
REQ-017 IDLE: ccwait=1 SHALL latch ccsnoopaddr into tag_addr, clear inv flag, and go to LOOKUP next cycle.
REQ-018 LOOKUP: SHALL hold tag_req=1 and a stable tag_addr until tag_ack=1; tag_ack SHALL register hit, state and data, and go to RESPOND.
REQ-019 Lookup latency SHALL be unbounded; changes on ccsnoopaddr after the latch SHALL be ignored.
REQ-020 RESPOND: ccsnoopdone=1; ccsnoophit=hit&(state==M|E); ccexclusivehit=hit&(state!=I); dstore=registered data when ccsnoophit=1, else 0.
REQ-021 ccinv=1 in any cycle of LOOKUP or RESPOND SHALL set a sticky inv flag.
REQ-022 wb_pending = inv flag & hit & state==M.
REQ-023 RESPOND SHALL exit when ccwait=0 and (!wb_pending or dwait=0).
REQ-024 On exit: go to UPDATE if hit; otherwise go to IDLE with no state write.
REQ-025 UPDATE: state_wen=1 for exactly one cycle, then IDLE.
REQ-026 state_new SHALL be I if the inv flag is set, otherwise S (M->S, E->S, S->S).
REQ-027 cpu_stall SHALL be 1 in LOOKUP, RESPOND and UPDATE, and 0 in IDLE.
REQ-028 ccwait=1 on the cycle UPDATE returns to IDLE SHALL start a new snoop on the following cycle; it SHALL NOT be dropped.
REQ-029 All outputs SHALL be registered or decoded from the registered state only; no combinational path from a bus input to a bus output.

Reset
REQ-030 nRST low SHALL force IDLE and clear inv, hit, state and data registers.
REQ-031 During reset, all outputs SHALL be 0 and tag_addr SHALL be 0.
REQ-032 Reset mid-snoop SHALL abandon the snoop with no state_wen issued.

Structure
REQ-033 coherence_pkg SHALL hold the MESI enum (I=2'b00, S=2'b01, E=2'b10, M=2'b11), word_t, longWord_t, and the responder state enum.
REQ-034 The MESI next-state rule SHALL be a package function; there SHALL be no sub-module.

Verification
REQ-035 Read snoop, line in M: ccwait=1, addr 0x0000_1040, tag_ack after 2 cycles with state M, data 0xDEAD_BEEF_0123_4567 -> ccsnoophit=1, ccexclusivehit=1, dstore=data; after ccwait falls, state_new=S for one cycle.
REQ-036 Invalidating snoop, line in M: as REQ-035 plus ccinv=1 for one cycle; hold dwait=1 for 3 cycles after ccwait falls -> FSM stays in RESPOND until dwait=0, then state_new=I.
REQ-037 Line in S, no ccinv -> ccsnoophit=0, ccexclusivehit=1, dstore=0, state_new=S.
REQ-038 Miss (tag_hit=0) -> ccsnoopdone=1 with both hits 0; return to IDLE with no state_wen; cpu_stall low 1 cycle after ccwait falls.
REQ-039 Back-to-back snoops 0x100 then 0x200, second ccwait asserted in the UPDATE cycle -> two separate lookups with the correct addresses.
REQ-040 nRST asserted during LOOKUP -> all outputs 0 immediately; no state_wen after release.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared coherence types: MESI encoding, bus word types, snoop responder FSM
// states and the MESI downgrade rule applied when a snoop completes.
package coherence_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] longWord_t;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        E = 2'b10,
        M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOOKUP  = 2'b01,
        RESPOND = 2'b10,
        UPDATE  = 2'b11
    } snoop_state_t;

    // A snooped valid line drops to S for a read, or to I when invalidated.
    function automatic mesi_t snoop_next_state(mesi_t cur, logic inv);
        if (inv || cur == I) return I;
        return S;
    endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Coherence bus snoop channel between the bus controller (master) and a
// cache's snoop responder (slave).
interface snoop_responder_if #(
    parameter int BLOCK_SIZE = 2
);
    localparam int DW = 32 * BLOCK_SIZE;

    logic          ccwait;
    logic          ccinv;
    logic [31:0]   ccsnoopaddr;
    logic          ccsnoophit;
    logic          ccexclusivehit;
    logic          ccsnoopdone;
    logic [DW-1:0] dstore;
    logic          dwait;

    modport master (
        output ccwait, ccinv, ccsnoopaddr, dwait,
        input  ccsnoophit, ccexclusivehit, ccsnoopdone, dstore
    );

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, dwait,
        output ccsnoophit, ccexclusivehit, ccsnoopdone, dstore
    );

endinterface

// File: rtl/snoop_responder.sv
// Snoop responder: looks up a snooped block in the tag array, answers the bus,
// waits out any writeback of supplied dirty data, then downgrades the line.
module snoop_responder
    import coherence_pkg::*;
#(
    parameter int  BLOCK_SIZE = 2,
    localparam int DW         = 32 * BLOCK_SIZE
) (
    input  logic          CLK,
    input  logic          nRST,
    snoop_responder_if.slave bus,
    output logic          tag_req,
    output word_t         tag_addr,
    input  logic          tag_ack,
    input  logic          tag_hit,
    input  logic [1:0]    tag_state,
    input  logic [DW-1:0] tag_data,
    output logic          state_wen,
    output logic [1:0]    state_new,
    output logic          cpu_stall
);

    snoop_state_t  state_q, state_d;
    word_t         addr_q;
    logic          inv_q;
    logic          hit_q;
    mesi_t         mesi_q;
    logic [DW-1:0] data_q;
    logic          wb_pending;
    logic          supply;

    // Dirty data handed over on an invalidating snoop must finish its writeback.
    assign wb_pending = inv_q & hit_q & (mesi_q == M);
    assign supply     = hit_q & ((mesi_q == M) | (mesi_q == E));
    assign tag_addr   = addr_q;

    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q <= '0;
            inv_q  <= 1'b0;
            hit_q  <= 1'b0;
            mesi_q <= I;
            data_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ccwait) begin
                        addr_q <= bus.ccsnoopaddr;
                        inv_q  <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (bus.ccinv) inv_q <= 1'b1;
                    if (tag_ack) begin
                        hit_q  <= tag_hit;
                        mesi_q <= mesi_t'(tag_state);
                        data_q <= tag_data;
                    end
                end
                RESPOND: begin
                    if (bus.ccinv) inv_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.ccwait) state_d = LOOKUP;
            LOOKUP:  if (tag_ack)    state_d = RESPOND;
            RESPOND: begin
                if (!bus.ccwait && (!wb_pending || !bus.dwait))
                    state_d = hit_q ? UPDATE : IDLE;
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so no bus input reaches a bus output.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        tag_req            = 1'b0;
        cpu_stall          = 1'b0;
        state_wen          = 1'b0;
        state_new          = I;
        bus.ccsnoopdone    = 1'b0;
        bus.ccsnoophit     = 1'b0;
        bus.ccexclusivehit = 1'b0;
        bus.dstore         = '0;
        unique case (state_q)
            LOOKUP: begin
                tag_req   = 1'b1;
                cpu_stall = 1'b1;
            end
            RESPOND: begin
                cpu_stall          = 1'b1;
                bus.ccsnoopdone    = 1'b1;
                bus.ccsnoophit     = supply;
                bus.ccexclusivehit = hit_q & (mesi_q != I);
                bus.dstore         = supply ? data_q : '0;
            end
            UPDATE: begin
                cpu_stall = 1'b1;
                state_wen = 1'b1;
                state_new = snoop_next_state(mesi_q, inv_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed vector table, hand-written
// back-to-back and reset sequences, and randomized snoops against a reference model.
module tb_snoop_responder;
    import coherence_pkg::*;

    localparam int BLOCK_SIZE = 2;
    localparam int DW         = 32 * BLOCK_SIZE;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          tag_req;
    word_t         tag_addr;
    logic          tag_ack;
    logic          tag_hit;
    logic [1:0]    tag_state;
    logic [DW-1:0] tag_data;
    logic          state_wen;
    logic [1:0]    state_new;
    logic          cpu_stall;

    snoop_responder_if #(.BLOCK_SIZE(BLOCK_SIZE)) bus ();

    snoop_responder #(.BLOCK_SIZE(BLOCK_SIZE)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.slave),
        .tag_req   (tag_req),
        .tag_addr  (tag_addr),
        .tag_ack   (tag_ack),
        .tag_hit   (tag_hit),
        .tag_state (tag_state),
        .tag_data  (tag_data),
        .state_wen (state_wen),
        .state_new (state_new),
        .cpu_stall (cpu_stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        word_t       addr;
        int          lat;
        logic        hit;
        logic [1:0]  st;
        logic [63:0] data;
        logic        inv_lk;
        logic        inv_rsp;
        int          hold;
        int          dw;
        logic        exp_sh;
        logic        exp_eh;
        logic [63:0] exp_ds;
        logic        exp_wen;
        logic [1:0]  exp_new;
        int          exp_extra;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] quiet_outputs();
        return 64'({bus.ccsnoopdone, bus.ccsnoophit, bus.ccexclusivehit,
                    tag_req, state_wen, state_new, cpu_stall});
    endfunction

    // Expected behaviour derived directly from the coherence rules.
    function automatic vec_t model(input vec_t t);
        logic invalidated;
        invalidated = t.inv_lk | t.inv_rsp;
        t.exp_sh    = t.hit && (t.st == M || t.st == E);
        t.exp_eh    = t.hit && (t.st != I);
        t.exp_ds    = t.exp_sh ? t.data : 64'h0;
        t.exp_wen   = t.hit;
        t.exp_new   = invalidated ? I : S;
        t.exp_extra = (invalidated && t.hit && t.st == M) ? t.dw : 0;
        return t;
    endfunction

    // Request, lookup with latency, and the response while ccwait is still high.
    task automatic snoop_front(input vec_t t, output int wait_ticks);
        int n = 0;
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = t.addr;
        do begin
            tick();
            n++;
        end while (!tag_req && n < 8);
        wait_ticks = n;
        check("lookup_req", 64'(tag_req), 64'(1));
        check("lookup_addr", 64'(tag_addr), 64'(t.addr));
        check("lookup_stall", 64'(cpu_stall), 64'(1));
        bus.ccsnoopaddr = ~t.addr;
        bus.ccinv       = t.inv_lk;
        for (int i = 0; i < t.lat; i++) begin
            tick();
            bus.ccinv = 1'b0;
            check("lookup_hold", 64'({tag_req, bus.ccsnoopdone, tag_addr}), 64'({2'b10, t.addr}));
        end
        tag_ack   = 1'b1;
        tag_hit   = t.hit;
        tag_state = t.st;
        tag_data  = t.data;
        tick();
        bus.ccinv = 1'b0;
        tag_ack   = 1'b0;
        tag_hit   = 1'($urandom);
        tag_state = 2'($urandom);
        tag_data  = {$urandom, $urandom};
        check("resp_done", 64'(bus.ccsnoopdone), 64'(1));
        check("resp_snoophit", 64'(bus.ccsnoophit), 64'(t.exp_sh));
        check("resp_exclhit", 64'(bus.ccexclusivehit), 64'(t.exp_eh));
        check("resp_dstore", bus.dstore, t.exp_ds);
        if (t.hold > 0) begin
            bus.ccinv = t.inv_rsp;
            for (int i = 0; i < t.hold; i++) begin
                tick();
                bus.ccinv = 1'b0;
                check("resp_held", 64'({bus.ccsnoopdone, tag_req}), 64'(2'b10));
                check("resp_held_dstore", bus.dstore, t.exp_ds);
            end
        end
    endtask

    // Drop ccwait, apply dwait, and observe the writeback wait and state update.
    task automatic snoop_back(input vec_t t);
        int         rem  = t.dw;
        int         resp = 0;
        int         wen  = 0;
        int         n    = 0;
        logic [1:0] nw   = 2'b00;
        bus.ccwait = 1'b0;
        do begin
            bus.dwait = (rem > 0);
            if (rem > 0) rem--;
            tick();
            n++;
            if (bus.ccsnoopdone) resp++;
            if (state_wen) begin
                wen++;
                nw = state_new;
            end
        end while (cpu_stall && n < 40);
        bus.dwait = 1'b0;
        check("drain_stall_low", 64'(cpu_stall), 64'(0));
        check("drain_resp_cycles", 64'(resp), 64'(t.exp_extra));
        check("drain_wen_count", 64'(wen), 64'(t.exp_wen));
        if (t.exp_wen) check("drain_state_new", 64'(nw), 64'(t.exp_new));
        check("drain_latency", 64'(n), 64'(t.exp_extra + 1 + int'(t.exp_wen)));
    endtask

    vec_t tbl [7];
    vec_t v, a, b;
    int   wt;
    int   bad;

    initial begin
        tbl[0] = '{32'h0000_1040, 2, 1'b1, M, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 0, 0,
                   1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, S, 0};
        tbl[1] = '{32'h0000_1040, 2, 1'b1, M, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 0, 3,
                   1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, I, 3};
        tbl[2] = '{32'h0000_2080, 1, 1'b1, S, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 0, 0,
                   1'b0, 1'b1, 64'h0, 1'b1, S, 0};
        tbl[3] = '{32'h0000_30C0, 3, 1'b0, M, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0, 0, 2,
                   1'b0, 1'b0, 64'h0, 1'b0, I, 0};
        tbl[4] = '{32'h4000_0100, 0, 1'b1, E, 64'h5555_6666_7777_8888, 1'b0, 1'b1, 1, 2,
                   1'b1, 1'b1, 64'h5555_6666_7777_8888, 1'b1, I, 0};
        tbl[5] = '{32'h0000_5000, 4, 1'b1, M, 64'h0BAD_F00D_CAFE_0001, 1'b0, 1'b0, 0, 2,
                   1'b1, 1'b1, 64'h0BAD_F00D_CAFE_0001, 1'b1, S, 0};
        tbl[6] = '{32'h0000_6040, 1, 1'b1, M, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 2, 2,
                   1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, I, 2};

        nRST            = 1'b0;
        bus.ccwait      = 1'b0;
        bus.ccinv       = 1'b0;
        bus.ccsnoopaddr = 32'h0;
        bus.dwait       = 1'b0;
        tag_ack         = 1'b0;
        tag_hit         = 1'b0;
        tag_state       = 2'b00;
        tag_data        = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", quiet_outputs(), 64'h0);
        check("reset_dstore", bus.dstore, 64'h0);
        check("reset_tag_addr", 64'(tag_addr), 64'h0);
        #2 nRST = 1'b1;
        tick();
        check("idle_after_reset", quiet_outputs(), 64'h0);

        for (int k = 0; k < 7; k++) begin
            snoop_front(tbl[k], wt);
            check("start_latency", 64'(wt), 64'(1));
            snoop_back(tbl[k]);
        end

        // Back-to-back: second request raised during the first snoop's UPDATE cycle.
        a = model('{32'h0000_0100, 1, 1'b1, M, 64'hFACE_0000_0000_0100, 1'b0, 1'b0, 0, 0,
                    1'b0, 1'b0, 64'h0, 1'b0, I, 0});
        b = model('{32'h0000_0200, 2, 1'b1, E, 64'hFACE_0000_0000_0200, 1'b0, 1'b0, 0, 0,
                    1'b0, 1'b0, 64'h0, 1'b0, I, 0});
        snoop_front(a, wt);
        bus.ccwait = 1'b0;
        tick();
        check("b2b_first_update", 64'({state_wen, state_new}), 64'({1'b1, S}));
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = 32'h0000_0200;
        snoop_front(b, wt);
        check("b2b_second_start", 64'(wt), 64'(2));
        snoop_back(b);

        // Reset in the middle of a lookup abandons the snoop.
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = 32'h0000_0ABC;
        tick();
        check("rst_mid_in_lookup", 64'(tag_req), 64'(1));
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_outputs", quiet_outputs(), 64'h0);
        check("rst_mid_dstore", bus.dstore, 64'h0);
        check("rst_mid_tag_addr", 64'(tag_addr), 64'h0);
        bus.ccwait = 1'b0;
        tag_ack    = 1'b1;
        tick();
        tick();
        #2 nRST = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (state_wen || cpu_stall) bad++;
        end
        tag_ack = 1'b0;
        check("rst_mid_no_wen", 64'(bad), 64'(0));

        for (int r = 0; r < 40; r++) begin
            v.addr    = $urandom & 32'hFFFF_FFF8;
            v.lat     = $urandom_range(0, 5);
            v.hit     = ($urandom_range(0, 3) != 0);
            v.st      = v.hit ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
            v.data    = {$urandom, $urandom};
            v.inv_lk  = ($urandom_range(0, 3) == 0);
            v.hold    = $urandom_range(0, 2);
            v.inv_rsp = (v.hold > 0) && ($urandom_range(0, 2) == 0);
            v.dw      = $urandom_range(0, 4);
            v = model(v);
            snoop_front(v, wt);
            check("rand_start_latency", 64'(wt), 64'(1));
            snoop_back(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
